// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  // Column 0 driven low out of reset
  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  // Index of the lowest-numbered bit that is low; 0 when all bits are high
  function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] v);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      if (!v[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider: one-clk tick every DIV clocks, shared with the
// segment driver.
module scan_tick #(
  parameter int unsigned DIV = 10_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  // Wrap to zero on the tick, otherwise count up
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  // Divider count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10_000,
  parameter int unsigned DEBOUNCE_TICKS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY   = 100,
  parameter int unsigned REPEAT_PERIOD  = 25
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [NUM_COLS-1:0] col_sel,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_down
);

  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

  logic [NUM_ROWS-1:0] sync1_q, sync2_q;
  logic                tick;
  logic                hit;
  logic [1:0]          low_row;
  logic [1:0]          col_idx;
  logic                accept;

  state_e              state_q, state_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  logic [1:0]          row_q, row_d;
  logic [DW-1:0]       deb_q, deb_d, deb_inc;
  logic [DW-1:0]       rel_q, rel_d, rel_inc;
  logic [KEY_W-1:0]    code_q, code_d;
  logic                valid_q, valid_d;
  logic                down_q, down_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
  // After the first repeat the counter restarts one period short of the
  // delay, so every later repeat reuses the same compare.
  localparam int unsigned REP_RELOAD =
    (REPEAT_PERIOD <= REPEAT_DELAY) ? (REPEAT_DELAY - REPEAT_PERIOD) : 0;
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  assign rep_inc = rep_q + RW'(1);
`endif

  scan_tick #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
    end
  end

  assign hit     = (sync2_q != '1);
  assign low_row = lowest_low(sync2_q);
  assign col_idx = lowest_low(col_q);
  assign deb_inc = deb_q + DW'(1);
  assign rel_inc = rel_q + DW'(1);

  // Next-state and output logic; everything advances only on a scan tick
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    deb_d   = deb_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;
    accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            row_d = low_row;
            deb_d = DW'(1);
            if (DEBOUNCE_TICKS <= 1) accept  = 1'b1;
            else                     state_d = DEBOUNCE;
          end else begin
            col_d = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
          end
        end
        DEBOUNCE: begin
          if (hit && (low_row == row_q)) begin
            deb_d = deb_inc;
            if (deb_inc == DW'(DEBOUNCE_TICKS)) accept = 1'b1;
          end else begin
            deb_d   = '0;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (!hit) begin
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
            if (rel_inc == DW'(DEBOUNCE_TICKS)) begin
              rel_d   = '0;
              down_d  = 1'b0;
              col_d   = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
              state_d = SCAN;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc == RW'(REPEAT_DELAY)) begin
              valid_d = 1'b1;
              rep_d   = RW'(REP_RELOAD);
            end else begin
              rep_d = rep_inc;
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
    if (accept) begin
      state_d = HELD;
      code_d  = {low_row, col_idx};
      valid_d = 1'b1;
      down_d  = 1'b1;
      deb_d   = '0;
      rel_d   = '0;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = '0;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      col_q   <= COL_RESET;
      row_q   <= '0;
      deb_q   <= '0;
      rel_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      deb_q   <= deb_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign col_sel   = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan: a physical keypad matrix model, hand-derived
// vector table and sequences, and a tick-level reference model.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int RD       = 5;
  localparam int RP       = 2;
`ifdef KEYPAD_REPEAT_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_sel;
  logic [3:0]  row_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed;   // bit r*4+c = key at row r, column c

  keypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEB)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_sel   (col_sel),
    .row_in    (row_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_sel[c]) row_in[r] = 1'b0;
  end

  int errors;
  int checks;
  int vcount;
  int vedge[$];

  // Reference model state
  int         k;
  int         m_mode;     // 0 scanning, 1 confirming press, 2 key held
  int         m_col, m_row, run, rel, rep, m_code;
  bit         m_valid, m_down;
  logic [3:0] sq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s (edge %0d): got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic [3:0] sense(input int col, input logic [15:0] p);
    logic [3:0] v;
    v = 4'hF;
    for (int r = 0; r < 4; r++) if (p[r*4+col]) v[r] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    k = 0; m_mode = 0; m_col = 0; m_row = 0;
    run = 0; rel = 0; rep = 0; m_code = 0;
    m_valid = 0; m_down = 0;
    sq.delete();
    sq.push_back(4'hF);
    sq.push_back(4'hF);
  endtask

  task automatic model_accept(input int row);
    m_row = row; m_code = row * 4 + m_col;
    m_valid = 1; m_down = 1; m_mode = 2; rel = 0; rep = 0;
  endtask

  // One clock edge of the model; rows seen by the scanner lag the pins by two clocks
  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] rs;
    int         low;
    bit         hit;
    rs = sq.pop_front();
    sq.push_back(raw);
    k++;
    m_valid = 0;
    if (k % SCAN_DIV == 0) begin
      hit = (rs != 4'hF);
      low = -1;
      for (int i = 3; i >= 0; i--) if (!rs[i]) low = i;
      if (m_mode == 0) begin
        if (hit) begin
          m_row = low; run = 1; m_mode = 1;
        end else m_col = (m_col + 1) % 4;
      end else if (m_mode == 1) begin
        if (hit && low == m_row) begin
          run++;
          if (run >= DEB) model_accept(low);
        end else begin
          run = 0; m_mode = 0;
        end
      end else begin
        if (!hit) begin
          rep = 0; rel++;
          if (rel >= DEB) begin
            rel = 0; m_down = 0; m_col = (m_col + 1) % 4; m_mode = 0;
          end
        end else begin
          rel = 0; rep++;
          if (R == 1 && rep >= RD && (rep - RD) % RP == 0) m_valid = 1;
        end
      end
    end
  endtask

  task automatic step();
    logic [3:0] raw, ec;
    raw = sense(m_col, pressed);
    @(posedge clk);
    model_edge(raw);
    #1;
    ec = 4'hF;
    ec[m_col] = 1'b0;
    check("model", int'({col_sel, key_code, key_valid, key_down}),
          int'({ec, 4'(m_code), m_valid, m_down}));
    if (key_valid) begin
      vcount++;
      vedge.push_back(k);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    vcount = 0;
    vedge.delete();
    #1;
    check("rst_col_sel", int'(col_sel), 'hE);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_down", int'(key_down), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] mask;
    int          code;
    int          valids;
    int          down;
  } vec_t;

  vec_t vt[$];
  int   exp_edges[$];

  initial begin
    rst_n = 1'b1; pressed = '0; errors = 0; checks = 0; vcount = 0;
    model_reset();
    #2;

    // No keys: column walks E->D->B->7->E, one step per tick
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      if (k == 3)  check("col_before_tick", int'(col_sel), 'hE);
      if (k == 4)  check("col_tick1", int'(col_sel), 'hD);
      if (k == 8)  check("col_tick2", int'(col_sel), 'hB);
      if (k == 12) check("col_tick3", int'(col_sel), 'h7);
      if (k == 16) check("col_wrap", int'(col_sel), 'hE);
    end
    check("idle_no_valid", vcount, 0);

    // Key row1/col1: accepted at edge 16, released after edge 20
    do_reset();
    pressed = 16'(1) << 5;
    for (int i = 0; i < 32; i++) begin
      step();
      if (k == 15) check("press_valid_early", int'(key_valid), 0);
      if (k == 16) begin
        check("press_valid", int'(key_valid), 1);
        check("press_code", int'(key_code), 5);
        check("press_down", int'(key_down), 1);
      end
      if (k == 17) check("press_valid_pulse", int'(key_valid), 0);
      if (k == 20) begin
        check("held_col_frozen", int'(col_sel), 'hD);
        pressed = '0;
      end
      if (k == 31) check("release_down_held", int'(key_down), 1);
      if (k == 32) begin
        check("release_down", int'(key_down), 0);
        check("release_col_adv", int'(col_sel), 'hB);
        check("release_code_kept", int'(key_code), 5);
      end
    end
    check("press_single_valid", vcount, 1);

    // Start a press on column 2, then reset while it is being debounced
    pressed = 16'(1) << 10;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      if (k == 20) begin
        check("redetect_valid", int'(key_valid), 1);
        check("redetect_code", int'(key_code), 'hA);
      end
    end
    pressed = '0;
    for (int i = 0; i < 20; i++) step();

    // Bounce: low 2 ticks, high 1, then low -> one valid at edge 24 only
    do_reset();
    pressed = 16'(1) << 4;
    for (int i = 0; i < 40; i++) begin
      step();
      if (k == 8)  pressed = '0;
      if (k == 12) pressed = 16'(1) << 4;
      if (k == 23) check("bounce_no_early_valid", vcount, 0);
      if (k == 24) begin
        check("bounce_valid", int'(key_valid), 1);
        check("bounce_code", int'(key_code), 4);
      end
    end
    check("bounce_single_valid", vcount, 1);
    pressed = '0;
    for (int i = 0; i < 20; i++) step();

    // Long hold: repeats 5,7,9,11 ticks after acceptance when enabled
    do_reset();
    pressed = 16'(1) << 5;
    exp_edges.delete();
    exp_edges.push_back(16);
    if (R == 1) begin
      exp_edges.push_back(36);
      exp_edges.push_back(44);
      exp_edges.push_back(52);
      exp_edges.push_back(60);
    end
    for (int i = 0; i < 80; i++) begin
      step();
      if (k == 64) pressed = '0;
    end
    check("repeat_count", vedge.size(), exp_edges.size());
    for (int i = 0; i < exp_edges.size() && i < vedge.size(); i++)
      check("repeat_edge", vedge[i], exp_edges[i]);

    // Table: from reset, hold mask for 38 clocks
    vt.push_back('{16'h0000, 'h0, 0,     0});
    vt.push_back('{16'h0020, 'h5, 1 + R, 1});
    vt.push_back('{16'h0808, 'h3, 1,     1});
    vt.push_back('{16'h8000, 'hF, 1,     1});
    vt.push_back('{16'h0400, 'hA, 1,     1});
    vt.push_back('{16'h0208, 'h9, 1 + R, 1});
    vt.push_back('{16'h1000, 'hC, 1 + R, 1});
    vt.push_back('{16'h0001, 'h0, 1 + R, 1});
    vt.push_back('{16'h4040, 'h6, 1,     1});
    for (int v = 0; v < vt.size(); v++) begin
      do_reset();
      pressed = vt[v].mask;
      for (int i = 0; i < 38; i++) step();
      check($sformatf("vec%0d_code", v), int'(key_code), vt[v].code);
      check($sformatf("vec%0d_valids", v), vcount, vt[v].valids);
      check($sformatf("vec%0d_down", v), int'(key_down), vt[v].down);
      pressed = '0;
      for (int i = 0; i < 20; i++) step();
    end

    // Randomized presses, bounces and occasional resets against the model
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int n, hold;
      logic [15:0] m;
      if ($urandom_range(0, 39) == 0) do_reset();
      n = $urandom_range(0, 2);
      m = '0;
      for (int j = 0; j < n; j++) m[$urandom_range(0, 15)] = 1'b1;
      pressed = m;
      hold = $urandom_range(1, 90);
      for (int i = 0; i < hold; i++) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
